// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply datapath.
//   - State encoding for the dot-product accumulator FSM.
//   - Default product width, so the multiplier result bus and the
//     accumulator input agree.
package mm_pkg;

    localparam int PROD_W_DEF = 64;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ACCUM = 2'd1;
    localparam state_t OUT   = 2'd2;

endpackage

// File: rtl/dot_product_accumulator_acc_adder.sv
// acc_adder: registered running sum with clear, enable and carry-out flag.
// Ports:
//   clk, reset  clock (rising edge), synchronous active-high reset
//   clr         zero the sum next edge (wins over en)
//   en          add zero-extended addend into the sum next edge
//   addend      PROD_W-bit unsigned value to add
//   sum         ACC_W-bit running sum (wraps modulo 2^ACC_W)
//   carry       combinational: the add performed this cycle carries out of ACC_W
// ACC_W must be >= PROD_W.
module acc_adder
    import mm_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = 72
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [PROD_W-1:0] addend,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    // One bit wider than the sum so the carry-out falls out of the add;
    // the cast zero-extends and also covers the ACC_W == PROD_W case.
    logic [ACC_W:0] sum_wide;

    assign sum_wide = {1'b0, sum} + (ACC_W+1)'(addend);
    assign carry    = en & sum_wide[ACC_W];

    always_ff @(posedge clk) begin
        if (reset || clr)
            sum <= '0;
        else if (en)
            sum <= sum_wide[ACC_W-1:0];
    end

endmodule

// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator: sums a programmed number of multiplier products.
// Ports:
//   clk, reset  clock (rising edge), synchronous active-high reset
//   start       begin a dot product (honoured only in IDLE)
//   len         number of products, latched with start (0 => immediate 0 result)
//   prod        unsigned product from the multiplier
//   prod_vld    one product per high cycle
//   acc_out     final sum, held until the next result
//   acc_vld     one-cycle pulse marking a new acc_out
//   busy        FSM in ACCUM or OUT
//   overflow    sticky per dot product: sum carried out of ACC_W
//   err_drop    sticky until reset: a product or start was discarded
module dot_product_accumulator
    import mm_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = 72,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_vld,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_vld,
    output logic              busy,
    output logic              overflow,
    output logic              err_drop
);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] count_inc;
    logic [ACC_W-1:0] sum;
    logic             carry;
    logic             start_acc;
    logic             prod_acc;
    logic             last_prod;

    assign start_acc = (state == IDLE) && start;
    assign prod_acc  = (state == ACCUM) && prod_vld;
    assign count_inc = count + LEN_W'(1);
    // len_q >= 1 in ACCUM, so count_inc never wraps before matching.
    assign last_prod = prod_acc && (count_inc == len_q);

    acc_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .clk    (clk),
        .reset  (reset),
        .clr    (start_acc),
        .en     (prod_acc),
        .addend (prod),
        .sum    (sum),
        .carry  (carry)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? OUT : ACCUM;
            ACCUM:   if (last_prod) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == ACCUM) || (state == OUT);
    end

    // Length counter, flags and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            err_drop <= 1'b0;
            acc_out  <= '0;
            acc_vld  <= 1'b0;
        end else begin
            if (start_acc) begin
                len_q    <= len;
                count    <= '0;
                overflow <= 1'b0;
            end else if (prod_acc) begin
                count <= count_inc;
                if (carry) overflow <= 1'b1;
            end

            // Anything arriving when the FSM cannot take it is lost.
            if ((prod_vld && state != ACCUM) || (start && state != IDLE))
                err_drop <= 1'b1;

            // Registering the result in OUT makes acc_vld coincide with
            // the FSM already being back in IDLE.
            acc_vld <= (state == OUT);
            if (state == OUT)
                acc_out <= sum;
        end
    end

endmodule
